// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 character-LCD controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_SETUP,
        ST_EN_HI,
        ST_HOLD,
        ST_WAIT,
        ST_IDLE
    } lcd_state_t;

    // Bit positions inside the LCD peripheral word
    localparam int BIT_ON  = 31;
    localparam int BIT_BL  = 30;
    localparam int BIT_TOG = 10;
    localparam int BIT_RS  = 8;

    // Instructions that need the long post-strobe wait
    localparam logic [7:0] OP_CLEAR = 8'h01;
    localparam logic [7:0] OP_HOME  = 8'h02;

    // Power-up init: 8-bit/2-line, display on, clear, entry mode increment
    localparam int INIT_LEN = 4;

    function automatic logic [7:0] init_cmd(input logic [1:0] step);
        case (step)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter that saturates at zero; done_o flags a zero count.
// Latency: load takes effect at the next edge; done_o is combinational from the count.
// Backpressure: none; the owner decides when to reload.
// Ports: clk_i/rst_i clock and sync reset (count <= RST_VAL), load_i/load_val_i reload,
//        done_o high while the count is zero.
module lcd_timer #(
    parameter int W       = 8,
    parameter int RST_VAL = 0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= W'(RST_VAL);
        end else if (load_i) begin
            r_cnt <= load_val_i;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign done_o = (r_cnt == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 8-bit controller: power-up init, then one timed RS/DATA/EN strobe per software toggle.
// Latency: a bypassed request reaches the bus one edge after the toggle; EN follows T_SETUP later.
// Backpressure: 1-deep pending slot; a toggle into a full slot overwrites it and sets overrun_o.
// Ports: lcd_reg_i is the peripheral word (on/backlight/toggle/RS/data); lcd_*_o drive the panel;
//        busy_o, init_done_o and overrun_o are status for software pacing.
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int T_PWRUP = 750000,
    parameter int T_SETUP = 2,
    parameter int T_EN    = 12,
    parameter int T_HOLD  = 2,
    parameter int T_CMD   = 2000,
    parameter int T_CLR   = 82000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] lcd_reg_i,
    output logic [7:0]  lcd_data_o,
    output logic        lcd_rs_o,
    output logic        lcd_rw_o,
    output logic        lcd_en_o,
    output logic        lcd_on_o,
    output logic        lcd_blon_o,
    output logic        busy_o,
    output logic        init_done_o,
    output logic        overrun_o
);

    localparam int T_MAX = (T_PWRUP > T_CLR) ? T_PWRUP : T_CLR;
    localparam int TW    = $clog2(T_MAX) + 1;

    lcd_state_t  r_state;
    logic [1:0]  r_step;
    logic        r_prev_tog;
    logic        r_slot_vld;
    logic        r_slot_rs;
    logic [7:0]  r_slot_dat;
    logic        r_rs;
    logic [7:0]  r_data;
    logic        r_en;
    logic        r_init_done;
    logic        r_overrun;
    logic        r_on;
    logic        r_blon;

    logic          w_req;
    logic          w_issue;
    logic          w_long_wait;
    logic          w_tmr_done;
    logic          w_tmr_load;
    logic [TW-1:0] w_tmr_val;
    logic          w_unused_bits;

    assign w_req       = lcd_reg_i[BIT_TOG] != r_prev_tog;
    assign w_issue     = (r_state == ST_IDLE) && (r_slot_vld || w_req);
    assign w_long_wait = !r_rs && ((r_data == OP_CLEAR) || (r_data == OP_HOME));
    assign w_unused_bits = ^{lcd_reg_i[29:11], lcd_reg_i[9]};

    // The timer is reloaded on every state exit with the length of the state being entered.
    // Exits from WAIT/PWRUP/IDLE all lead to SETUP (or IDLE, where the count is ignored).
    always_comb begin
        w_tmr_load = (r_state == ST_IDLE) ? w_issue : w_tmr_done;
        w_tmr_val  = TW'(T_SETUP - 1);
        case (r_state)
            ST_SETUP: w_tmr_val = TW'(T_EN - 1);
            ST_EN_HI: w_tmr_val = TW'(T_HOLD - 1);
            ST_HOLD:  w_tmr_val = w_long_wait ? TW'(T_CLR - 1) : TW'(T_CMD - 1);
            default:  w_tmr_val = TW'(T_SETUP - 1);
        endcase
    end

    lcd_timer #(
        .W       (TW),
        .RST_VAL (T_PWRUP)
    ) u_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (w_tmr_load),
        .load_val_i (w_tmr_val),
        .done_o     (w_tmr_done)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_PWRUP;
            r_step      <= 2'd0;
            r_prev_tog  <= lcd_reg_i[BIT_TOG];
            r_slot_vld  <= 1'b0;
            r_slot_rs   <= 1'b0;
            r_slot_dat  <= 8'h00;
            r_rs        <= 1'b0;
            r_data      <= 8'h00;
            r_en        <= 1'b0;
            r_init_done <= 1'b0;
            r_overrun   <= 1'b0;
            r_on        <= 1'b0;
            r_blon      <= 1'b0;
        end else begin
            r_prev_tog <= lcd_reg_i[BIT_TOG];
            r_on       <= lcd_reg_i[BIT_ON];
            r_blon     <= lcd_reg_i[BIT_BL];

            // Slot payload is harmless to capture on a bypass since vld stays low.
            if (w_req) begin
                r_slot_rs  <= lcd_reg_i[BIT_RS];
                r_slot_dat <= lcd_reg_i[7:0];
            end
            if (w_issue) begin
                // Draining a full slot frees it, so a same-cycle request refills it cleanly.
                r_slot_vld <= r_slot_vld && w_req;
            end else if (w_req) begin
                if (r_slot_vld) begin
                    r_overrun <= 1'b1;
                end
                r_slot_vld <= 1'b1;
            end

            case (r_state)
                ST_PWRUP: begin
                    if (w_tmr_done) begin
                        r_state <= ST_SETUP;
                        r_step  <= 2'd0;
                        r_rs    <= 1'b0;
                        r_data  <= init_cmd(2'd0);
                    end
                end
                ST_SETUP: begin
                    if (w_tmr_done) begin
                        r_state <= ST_EN_HI;
                        r_en    <= 1'b1;
                    end
                end
                ST_EN_HI: begin
                    if (w_tmr_done) begin
                        r_state <= ST_HOLD;
                        r_en    <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (w_tmr_done) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (w_tmr_done) begin
                        if (r_init_done) begin
                            r_state <= ST_IDLE;
                        end else if (r_step == 2'(INIT_LEN - 1)) begin
                            r_init_done <= 1'b1;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_step  <= r_step + 2'd1;
                            r_rs    <= 1'b0;
                            r_data  <= init_cmd(r_step + 2'd1);
                            r_state <= ST_SETUP;
                        end
                    end
                end
                ST_IDLE: begin
                    if (w_issue) begin
                        r_state <= ST_SETUP;
                        r_rs    <= r_slot_vld ? r_slot_rs  : lcd_reg_i[BIT_RS];
                        r_data  <= r_slot_vld ? r_slot_dat : lcd_reg_i[7:0];
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign lcd_data_o  = r_data;
    assign lcd_rs_o    = r_rs;
    assign lcd_rw_o    = 1'b0;
    assign lcd_en_o    = r_en;
    assign lcd_on_o    = r_on;
    assign lcd_blon_o  = r_blon;
    assign busy_o      = (r_state != ST_IDLE) || r_slot_vld;
    assign init_done_o = r_init_done;
    assign overrun_o   = r_overrun;

endmodule

// File: tb/tb_lcd_ctrl.sv
module tb_lcd_ctrl;

    localparam int P_PWRUP = 20;
    localparam int P_SETUP = 2;
    localparam int P_EN    = 3;
    localparam int P_HOLD  = 2;
    localparam int P_CMD   = 10;
    localparam int P_CLR   = 30;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [31:0] lcd_reg;
    logic [7:0]  lcd_data_o;
    logic        lcd_rs_o, lcd_rw_o, lcd_en_o, lcd_on_o, lcd_blon_o;
    logic        busy_o, init_done_o, overrun_o;

    always #5 clk = ~clk;

    lcd_ctrl #(
        .T_PWRUP (P_PWRUP),
        .T_SETUP (P_SETUP),
        .T_EN    (P_EN),
        .T_HOLD  (P_HOLD),
        .T_CMD   (P_CMD),
        .T_CLR   (P_CLR)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .lcd_reg_i   (lcd_reg),
        .lcd_data_o  (lcd_data_o),
        .lcd_rs_o    (lcd_rs_o),
        .lcd_rw_o    (lcd_rw_o),
        .lcd_en_o    (lcd_en_o),
        .lcd_on_o    (lcd_on_o),
        .lcd_blon_o  (lcd_blon_o),
        .busy_o      (busy_o),
        .init_done_o (init_done_o),
        .overrun_o   (overrun_o)
    );

    // post: cycles with EN low after the strobe until the next EN rise or busy_o falling
    // (HOLD + WAIT [+ IDLE] [+ SETUP]); negative means not checked.
    typedef struct {
        logic       rs;
        logic [7:0] dat;
        int         post;
        logic       done;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic push(input logic rs, input logic [7:0] dat, input int post, input logic done);
        exp_t e;
        e.rs = rs; e.dat = dat; e.post = post; e.done = done;
        q.push_back(e);
    endtask

    // last_post depends on whether a request is pending when init finishes
    task automatic push_init(input int last_post);
        push(1'b0, 8'h38, P_HOLD + P_CMD + P_SETUP, 1'b0);
        push(1'b0, 8'h0C, P_HOLD + P_CMD + P_SETUP, 1'b0);
        push(1'b0, 8'h01, P_HOLD + P_CLR + P_SETUP, 1'b0);
        push(1'b0, 8'h06, last_post, 1'b0);
    endtask

    task automatic send(input logic rs, input logic [7:0] dat);
        @(posedge clk); #1;
        lcd_reg[8]   = rs;
        lcd_reg[7:0] = dat;
        lcd_reg[10]  = ~lcd_reg[10];
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k;
        for (k = 0; k < budget; k++) begin
            @(posedge clk); #1;
            if (!busy_o) break;
        end
        if (k == budget) begin
            n_chk++;
            $display("FAIL %s: busy_o still high after %0d cycles", name, budget);
        end
        repeat (2) @(negedge clk);
    endtask

    // Monitor: pops one expectation per EN rising edge and measures strobe timing.
    logic       prev_en  = 1'b0;
    logic       in_post  = 1'b0;
    logic       have_cur = 1'b0;
    int         post_cnt = 0;
    int         en_cnt   = 0;
    int         stable_cnt = 0;
    logic [8:0] prev_bus = '0;
    logic [8:0] rise_bus = '0;
    exp_t       cur;

    always @(negedge clk) begin
        logic [8:0] bus;
        bus = {lcd_rs_o, lcd_data_o};
        if (rst_i) begin
            prev_en    = 1'b0;
            in_post    = 1'b0;
            have_cur   = 1'b0;
            stable_cnt = 0;
            prev_bus   = bus;
        end else begin
            if (bus == prev_bus) stable_cnt++;
            else stable_cnt = 1;
            prev_bus = bus;

            if (in_post) begin
                if (lcd_en_o || !busy_o) begin
                    if (cur.post >= 0) chk("post_wait", post_cnt, cur.post);
                    if (!lcd_en_o) chk("bus_hold_idle", {23'd0, bus}, {23'd0, rise_bus});
                    in_post = 1'b0;
                end else begin
                    post_cnt++;
                end
            end

            if (lcd_en_o && !prev_en) begin
                if (q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_strobe: rs=%0b data=%0h with nothing expected", lcd_rs_o, lcd_data_o);
                    have_cur = 1'b0;
                end else begin
                    cur = q.pop_front();
                    have_cur = 1'b1;
                    chk("strobe_rs", {31'd0, lcd_rs_o}, {31'd0, cur.rs});
                    chk("strobe_data", {24'd0, lcd_data_o}, {24'd0, cur.dat});
                    chk("strobe_setup", {31'd0, stable_cnt >= P_SETUP + 1}, 32'd1);
                    chk("strobe_init_done", {31'd0, init_done_o}, {31'd0, cur.done});
                end
                en_cnt   = 1;
                rise_bus = bus;
            end else if (lcd_en_o) begin
                en_cnt++;
            end

            if (!lcd_en_o && prev_en) begin
                chk("en_width", en_cnt, P_EN);
                chk("bus_hold", {23'd0, bus}, {23'd0, rise_bus});
                in_post  = have_cur;
                post_cnt = 1;
            end
            prev_en = lcd_en_o;
        end
    end

    initial begin
        bit got_en;
        rst_i   = 1'b1;
        lcd_reg = 32'h8000_0000;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", {24'd0, lcd_data_o}, 32'd0);
        chk("rst_rs", {31'd0, lcd_rs_o}, 32'd0);
        chk("rst_en", {31'd0, lcd_en_o}, 32'd0);
        chk("rst_rw", {31'd0, lcd_rw_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd1);
        chk("rst_init_done", {31'd0, init_done_o}, 32'd0);
        chk("rst_overrun", {31'd0, overrun_o}, 32'd0);
        chk("rst_on", {31'd0, lcd_on_o}, 32'd0);
        rst_i = 1'b0;
        push_init(P_HOLD + P_CMD);
        @(posedge clk); #1;
        chk("on_follow", {31'd0, lcd_on_o}, 32'd1);
        chk("blon_follow", {31'd0, lcd_blon_o}, 32'd0);

        // Plain init sequence
        wait_idle(400, "init_timeout");
        chk("init_done", {31'd0, init_done_o}, 32'd1);
        chk("init_overrun", {31'd0, overrun_o}, 32'd0);
        chk("init_queue_drained", q.size(), 32'd0);

        // Data write, short wait
        push(1'b1, 8'h41, P_HOLD + P_CMD, 1'b1);
        send(1'b1, 8'h41);
        wait_idle(200, "data_timeout");

        // Clear display, long wait
        push(1'b0, 8'h01, P_HOLD + P_CLR, 1'b1);
        send(1'b0, 8'h01);
        wait_idle(200, "clear_timeout");

        // Three toggles during one transfer: only the last survives
        push(1'b1, 8'h50, P_HOLD + P_CMD + 1 + P_SETUP, 1'b1);
        send(1'b1, 8'h50);
        repeat (3) @(posedge clk);
        send(1'b1, 8'h41);
        send(1'b1, 8'h42);
        send(1'b1, 8'h43);
        push(1'b1, 8'h43, P_HOLD + P_CMD, 1'b1);
        chk("overrun_set", {31'd0, overrun_o}, 32'd1);
        wait_idle(200, "overrun_timeout");
        chk("overrun_sticky", {31'd0, overrun_o}, 32'd1);
        chk("overrun_queue_drained", q.size(), 32'd0);

        // Reset while EN is high, then a request queued during the replayed init
        push(1'b1, 8'h55, -1, 1'b1);
        send(1'b1, 8'h55);
        got_en = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk); #1;
            if (lcd_en_o) begin
                got_en = 1'b1;
                break;
            end
        end
        if (!got_en) begin
            n_chk++;
            $display("FAIL en_wait_timeout: lcd_en_o never rose");
        end
        @(posedge clk); #1;
        rst_i = 1'b1;
        @(posedge clk); #1;
        chk("midrst_en", {31'd0, lcd_en_o}, 32'd0);
        chk("midrst_init_done", {31'd0, init_done_o}, 32'd0);
        chk("midrst_overrun", {31'd0, overrun_o}, 32'd0);
        chk("midrst_busy", {31'd0, busy_o}, 32'd1);
        chk("midrst_data", {24'd0, lcd_data_o}, 32'd0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        push_init(P_HOLD + P_CMD + 1 + P_SETUP);
        push(1'b1, 8'h48, P_HOLD + P_CMD, 1'b1);
        repeat (3) @(posedge clk);
        send(1'b1, 8'h48);
        wait_idle(400, "reinit_timeout");
        chk("reinit_done", {31'd0, init_done_o}, 32'd1);
        chk("reinit_overrun", {31'd0, overrun_o}, 32'd0);
        chk("reinit_queue_drained", q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
